// File: rtl/muldiv_unit_pkg.sv
// Shared definitions for the iterative multiply/divide unit:
// the mul/div control codes, the iteration count and a small sign helper.
package muldiv_unit_pkg;

    // Number of shift/add or shift/subtract iterations for the 32-bit datapath.
    localparam int MD_CYCLES = 32;

    typedef logic [3:0] md_ctl_t;

    // Decoded mul/div control codes.
    localparam md_ctl_t MD_NOP   = 4'd0;
    localparam md_ctl_t MD_MULT  = 4'd1;
    localparam md_ctl_t MD_MULTU = 4'd2;
    localparam md_ctl_t MD_DIV   = 4'd3;
    localparam md_ctl_t MD_DIVU  = 4'd4;
    localparam md_ctl_t MD_MFHI  = 4'd5;
    localparam md_ctl_t MD_MFLO  = 4'd6;
    localparam md_ctl_t MD_MTHI  = 4'd7;
    localparam md_ctl_t MD_MTLO  = 4'd8;

    // Two's-complement negate when neg is set; used both to take magnitudes
    // and to restore the sign of a 32-bit result.
    function automatic logic [31:0] md_neg32(input logic [31:0] v, input logic neg);
        return neg ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/muldiv_unit_core.sv
// Iterative unsigned datapath: one 64-bit shift register shared by the
// multiply ({product_hi, multiplier}) and divide ({remainder, quotient})
// loops, a 32-bit operand register and the iteration counter.
module md_core
    import muldiv_unit_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_load,
    input  logic        i_step,
    input  logic        i_div,
    input  logic [31:0] i_opa,
    input  logic [31:0] i_opb,
    output logic [63:0] o_acc,
    output logic        o_last
);

    localparam int CW = $clog2(MD_CYCLES);

    logic [63:0]   r_acc;
    logic [31:0]   r_opb;
    logic [CW-1:0] r_count;
    logic          r_div;

    logic [32:0]   w_mul_sum;
    logic [32:0]   w_div_shift;
    logic [33:0]   w_div_diff;
    logic          w_no_borrow;
    logic [63:0]   w_acc_next;

    // Multiply step: add the multiplicand into the upper half when the
    // current multiplier bit is set, then shift the whole register right.
    assign w_mul_sum   = {1'b0, r_acc[63:32]} + (r_acc[0] ? {1'b0, r_opb} : 33'd0);

    // Divide step: shift the next dividend bit into the partial remainder and
    // trial-subtract the divisor; the quotient bit is "no borrow".
    assign w_div_shift = r_acc[63:31];
    assign w_div_diff  = {1'b0, w_div_shift} - {2'b00, r_opb};
    assign w_no_borrow = ~w_div_diff[33];

    assign w_acc_next  = r_div
        ? {(w_no_borrow ? w_div_diff[31:0] : w_div_shift[31:0]), r_acc[30:0], w_no_borrow}
        : {w_mul_sum, r_acc[31:1]};

    assign o_acc  = r_acc;
    assign o_last = (r_count == CW'(MD_CYCLES - 1));

    // Load operands on accept, then advance one iteration per enabled edge.
    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_acc   <= '0;
            r_opb   <= '0;
            r_count <= '0;
            r_div   <= 1'b0;
        end else if (i_load) begin
            // Multiply keeps the multiplier in the low half and adds opa;
            // divide keeps the dividend in the low half and subtracts opb.
            r_acc   <= {32'd0, (i_div ? i_opa : i_opb)};
            r_opb   <= i_div ? i_opb : i_opa;
            r_count <= '0;
            r_div   <= i_div;
        end else if (i_step) begin
            r_acc   <= w_acc_next;
            r_count <= r_count + CW'(1);
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// EXE-stage multiply/divide unit: control FSM, sign handling, architectural
// HI/LO registers and the stall/read-data logic around the md_core datapath.
module muldiv_unit
    import muldiv_unit_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        pause,
    input  logic [3:0]  ctl,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] res,
    output logic        stall,
    output logic        busy
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DIV  = 2'd2;
    localparam logic [1:0] S_FIX  = 2'd3;

    logic [1:0]  r_state;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic        r_busy;
    logic        r_neg_q;   // product / quotient must be negated
    logic        r_neg_r;   // remainder takes the (negative) dividend sign
    logic        r_is_div;

    logic        w_idle;
    logic        w_mul_op;
    logic        w_div_op;
    logic        w_signed;
    logic        w_a_neg;
    logic        w_b_neg;
    logic        w_start;
    logic [63:0] w_acc;
    logic        w_last;
    logic [63:0] w_prod_fix;

    assign w_idle   = (r_state == S_IDLE);
    assign w_mul_op = (ctl == MD_MULT) || (ctl == MD_MULTU);
    assign w_div_op = (ctl == MD_DIV)  || (ctl == MD_DIVU);
    assign w_signed = (ctl == MD_MULT) || (ctl == MD_DIV);
    assign w_a_neg  = w_signed & a[31];
    assign w_b_neg  = w_signed & b[31];
    assign w_start  = w_idle & ~pause & (w_mul_op | w_div_op);

    md_core u_core (
        .clk    (clk),
        .rst    (rst),
        .i_load (w_start),
        .i_step ((r_state == S_MUL) || (r_state == S_DIV)),
        .i_div  (w_div_op),
        .i_opa  (md_neg32(a, w_a_neg)),
        .i_opb  (md_neg32(b, w_b_neg)),
        .o_acc  (w_acc),
        .o_last (w_last)
    );

    assign w_prod_fix = r_neg_q ? (~w_acc + 64'd1) : w_acc;

    // Sequence accept -> iterate -> sign fix, and own the HI/LO registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= S_IDLE;
            r_hi     <= '0;
            r_lo     <= '0;
            r_busy   <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_is_div <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_state  <= w_div_op ? S_DIV : S_MUL;
                        r_busy   <= 1'b1;
                        r_neg_q  <= w_a_neg ^ w_b_neg;
                        r_neg_r  <= w_a_neg;
                        r_is_div <= w_div_op;
                    end else if (!pause && ctl == MD_MTHI) begin
                        r_hi <= a;
                    end else if (!pause && ctl == MD_MTLO) begin
                        r_lo <= a;
                    end
                end
                S_MUL, S_DIV: begin
                    if (w_last) r_state <= S_FIX;
                end
                default: begin
                    if (r_is_div) begin
                        r_lo <= md_neg32(w_acc[31:0], r_neg_q);
                        r_hi <= md_neg32(w_acc[63:32], r_neg_r);
                    end else begin
                        r_lo <= w_prod_fix[31:0];
                        r_hi <= w_prod_fix[63:32];
                    end
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Read port for MFHI/MFLO; zero whenever no read is being served.
    // NOTE: the default assignment first keeps this purely combinational
    // (no latch) on paths that do not select HI or LO.
    always_comb begin
        res = 32'd0;
        if (w_idle && ctl == MD_MFHI) res = r_hi;
        if (w_idle && ctl == MD_MFLO) res = r_lo;
    end

    assign stall = ~w_idle & (ctl != MD_NOP);
    assign busy  = r_busy;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed + random bench for muldiv_unit. Expected HI/LO pairs go into a
// scoreboard queue when an op is issued and are compared via MFHI/MFLO when
// the unit drops busy.
module tb_muldiv_unit;
    import muldiv_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        pause;
    logic [3:0]  ctl;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        stall;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    logic [63:0] sb_exp[$];
    string       sb_tag[$];
    logic [63:0] last_hilo;

    always #5 clk = ~clk;

    muldiv_unit dut (
        .clk   (clk),
        .rst   (rst),
        .pause (pause),
        .ctl   (ctl),
        .a     (a),
        .b     (b),
        .res   (res),
        .stall (stall),
        .busy  (busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Independent reference: plain 64-bit arithmetic plus the divide-by-zero rules.
    function automatic logic [63:0] model(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y);
        longint sx;
        longint sy;
        longint q;
        longint r;
        logic [63:0] ux;
        logic [63:0] uy;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = {32'd0, x};
        uy = {32'd0, y};
        case (op)
            MD_MULTU: return ux * uy;
            MD_MULT:  return 64'(sx * sy);
            MD_DIVU:  begin
                if (y == 32'd0) return {x, 32'hFFFF_FFFF};
                return {x % y, x / y};
            end
            default: begin
                if (y == 32'd0) return {x, (x[31] ? 32'h0000_0001 : 32'hFFFF_FFFF)};
                q = sx / sy;
                r = sx % sy;
                return {r[31:0], q[31:0]};
            end
        endcase
    endfunction

    // Pop the oldest expectation and compare it against MFHI/MFLO reads.
    task automatic read_back();
        logic [63:0] exp;
        string       tag;
        exp = sb_exp.pop_front();
        tag = sb_tag.pop_front();
        last_hilo = exp;
        ctl = MD_MFHI;
        #1;
        check({tag, "_hi"}, res, exp[63:32]);
        check({tag, "_rd_stall"}, 32'(stall), 32'd0);
        ctl = MD_MFLO;
        #1;
        check({tag, "_lo"}, res, exp[31:0]);
        ctl = MD_NOP;
    endtask

    // Issue one op, count busy cycles (bounded), then read the result back.
    task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] x,
                          input logic [31:0] y, input logic [63:0] exp, input logic hold_pause);
        int n;
        sb_exp.push_back(exp);
        sb_tag.push_back(tag);
        @(posedge clk); #1;
        ctl = op; a = x; b = y; pause = 1'b0;
        @(posedge clk); #1;
        ctl = MD_NOP; pause = hold_pause;
        n = 0;
        while (n < 100) begin
            @(negedge clk);
            if (!busy) break;
            n++;
        end
        check({tag, "_busy_cycles"}, 32'(n), 32'd33);
        pause = 1'b0;
        read_back();
    endtask

    initial begin
        int          n;
        logic [3:0]  op;
        logic [31:0] x;
        logic [31:0] y;

        rst = 1'b0; pause = 1'b0; ctl = MD_NOP; a = '0; b = '0;
        last_hilo = '0;

        // Reset state, observed while reset is held.
        #2;
        check("rst_busy", 32'(busy), 32'd0);
        ctl = MD_MFLO; #1;
        check("rst_res", res, 32'd0);
        ctl = MD_MULT; #1;
        check("rst_stall", 32'(stall), 32'd0);
        ctl = MD_NOP;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;

        // Directed arithmetic cases.
        run_op("multu", MD_MULTU, 32'hFFFF_FFFE, 32'd3, 64'h0000_0002_FFFF_FFFA, 1'b0);
        run_op("mult",  MD_MULT,  32'hFFFF_FFFE, 32'd3, 64'hFFFF_FFFF_FFFF_FFFA, 1'b0);
        run_op("div_neg", MD_DIV, 32'hFFFF_FFF9, 32'd2, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0);
        run_op("div_ovf", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, 1'b0);
        run_op("divu_z", MD_DIVU, 32'd7, 32'd0, 64'h0000_0007_FFFF_FFFF, 1'b0);
        run_op("div_zpos", MD_DIV, 32'd9, 32'd0, 64'h0000_0009_FFFF_FFFF, 1'b0);
        run_op("div_zneg", MD_DIV, 32'hFFFF_FFFB, 32'd0, 64'hFFFF_FFFB_0000_0001, 1'b0);
        run_op("mult_pause", MD_MULT, 32'h0000_1234, 32'hFFFF_FFF0, 64'hFFFF_FFFF_FFFE_DCC0, 1'b1);

        // MFLO presented 5 cycles after accept: stalls through FIX, then reads.
        sb_exp.push_back(64'h0000_0000_0001_2340);
        sb_tag.push_back("mflo_wait");
        @(posedge clk); #1;
        ctl = MD_MULT; a = 32'h0000_1234; b = 32'h0000_0010;
        @(posedge clk); #1;
        ctl = MD_NOP;
        repeat (5) @(posedge clk);
        #1 ctl = MD_MFLO;
        n = 0;
        while (n < 100) begin
            @(negedge clk);
            if (!stall) break;
            n++;
        end
        check("mflo_stall_cycles", 32'(n), 32'd28);
        check("mflo_wait_res", res, 32'h0001_2340);
        ctl = MD_NOP;
        read_back();

        // pause=1 in IDLE: neither MULT nor MTHI takes effect.
        @(posedge clk); #1;
        pause = 1'b1; ctl = MD_MULT; a = 32'd5; b = 32'd5;
        repeat (3) @(posedge clk);
        #1;
        check("pause_busy", 32'(busy), 32'd0);
        ctl = MD_MTHI; a = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        pause = 1'b0; ctl = MD_MFHI; #1;
        check("pause_hi_kept", res, last_hilo[63:32]);
        ctl = MD_NOP;

        // MTHI / MTLO followed by MFHI / MFLO on the next cycle.
        @(posedge clk); #1;
        ctl = MD_MTHI; a = 32'h1234_5678;
        @(posedge clk); #1;
        ctl = MD_MFHI; #1;
        check("mthi_res", res, 32'h1234_5678);
        check("mthi_stall", 32'(stall), 32'd0);
        ctl = MD_MTLO; a = 32'hCAFE_0001;
        @(posedge clk); #1;
        ctl = MD_MFLO; #1;
        check("mtlo_res", res, 32'hCAFE_0001);
        ctl = MD_NOP;

        // Reset mid-DIV at count=10: result discarded, HI/LO cleared.
        @(posedge clk); #1;
        ctl = MD_DIV; a = 32'd100; b = 32'd7;
        @(posedge clk); #1;
        ctl = MD_NOP;
        repeat (10) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        check("midrst_busy", 32'(busy), 32'd0);
        ctl = MD_MFHI; #1;
        check("midrst_hi", res, 32'd0);
        ctl = MD_MFLO; #1;
        check("midrst_lo", res, 32'd0);
        ctl = MD_NOP;
        @(posedge clk); #1 rst = 1'b1;
        ctl = MD_MFHI; #1;
        check("postrst_hi", res, 32'd0);
        ctl = MD_NOP;

        run_op("multu_6x7", MD_MULTU, 32'd6, 32'd7, 64'd42, 1'b0);

        // Random operands against the arithmetic model.
        for (int i = 0; i < 8; i++) begin
            op = 4'(MD_MULT + 4'($urandom_range(0, 3)));
            x  = $urandom;
            y  = (i % 2 == 0) ? $urandom : 32'($urandom_range(1, 1000));
            if (y == 32'd0) y = 32'd3;
            run_op($sformatf("rand%0d", i), op, x, y, model(op, x, y), 1'(i % 3 == 0));
        end

        check("sb_empty", 32'(sb_exp.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
